// File: rtl/dest_track_fwd_pkg.sv
// Shared encodings for destination tracking and operand forwarding.
// Forward selects, the never-forwarded register, default widths.
package dest_track_fwd_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_MEM     = 2'd1,
        FWD_WB      = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/dest_track_fwd_if.sv
// Bundle between the EX-stage control logic and the destination tracker.
// master drives EX/ID fields and observes tracked stages; slave is the tracker.
interface dest_track_fwd_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic [REG_W-1:0] ex_write_reg;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;

    logic [REG_W-1:0] mem_write_reg;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [REG_W-1:0] wb_write_reg;
    logic             wb_reg_write;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             load_use_stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output stall, flush, ex_write_reg, ex_reg_write, ex_mem_read,
               ex_rs, ex_rt, id_rs, id_rt,
        input  mem_write_reg, mem_reg_write, mem_mem_read, wb_write_reg,
               wb_reg_write, forward_a, forward_b, load_use_stall, stall_count
    );

    modport slave (
        input  stall, flush, ex_write_reg, ex_reg_write, ex_mem_read,
               ex_rs, ex_rt, id_rs, id_rt,
        output mem_write_reg, mem_reg_write, mem_mem_read, wb_write_reg,
               wb_reg_write, forward_a, forward_b, load_use_stall, stall_count
    );

endinterface

// File: rtl/dest_track_fwd_fwd_select.sv
// Operand forward select: picks MEM over WB result when the source matches.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module fwd_select
    import dest_track_fwd_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic [REG_W-1:0] mem_reg,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             wb_wr,
    output logic [1:0]       sel
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

    // MEM is checked first: it carries the newer value of a shared destination.
    always_comb begin
        sel = FWD_REGFILE;
        if (mem_wr && (mem_reg != ZERO) && (mem_reg == src_reg)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_reg != ZERO) && (wb_reg == src_reg)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/dest_track_fwd.sv
// Tracks EX destinations through MEM/WB; drives forward selects and load-use stall.
// Latency: EX->MEM 1 cycle, EX->WB 2 cycles; forward/stall outputs combinational.
// Backpressure: stall freezes every register and masks flush and counting.
module dest_track_fwd
    import dest_track_fwd_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    dest_track_fwd_if.slave bus
);

    localparam logic [REG_W-1:0] ZERO    = REG_W'(REG_ZERO);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [REG_W-1:0] wreg;
        logic             reg_write;
        logic             mem_read;
    } mem_stage_t;

    typedef struct packed {
        logic [REG_W-1:0] wreg;
        logic             reg_write;
    } wb_stage_t;

    mem_stage_t       mem_q;
    wb_stage_t        wb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;

    // A flushed entry keeps its register number; only its enables are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!bus.stall) begin
            mem_q.wreg      <= bus.ex_write_reg;
            mem_q.reg_write <= bus.ex_reg_write & ~bus.flush;
            mem_q.mem_read  <= bus.ex_mem_read & ~bus.flush;
            wb_q.wreg       <= mem_q.wreg;
            wb_q.reg_write  <= mem_q.reg_write;
        end
    end

    always_comb begin
        load_use = 1'b0;
        if (bus.ex_mem_read && bus.ex_reg_write && !bus.flush &&
            (bus.ex_write_reg != ZERO) &&
            ((bus.ex_write_reg == bus.id_rs) || (bus.ex_write_reg == bus.id_rt))) begin
            load_use = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!bus.stall && load_use && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src_reg (bus.ex_rs),
        .mem_reg (mem_q.wreg),
        .mem_wr  (mem_q.reg_write),
        .wb_reg  (wb_q.wreg),
        .wb_wr   (wb_q.reg_write),
        .sel     (bus.forward_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src_reg (bus.ex_rt),
        .mem_reg (mem_q.wreg),
        .mem_wr  (mem_q.reg_write),
        .wb_reg  (wb_q.wreg),
        .wb_wr   (wb_q.reg_write),
        .sel     (bus.forward_b)
    );

    assign bus.mem_write_reg  = mem_q.wreg;
    assign bus.mem_reg_write  = mem_q.reg_write;
    assign bus.mem_mem_read   = mem_q.mem_read;
    assign bus.wb_write_reg   = wb_q.wreg;
    assign bus.wb_reg_write   = wb_q.reg_write;
    assign bus.load_use_stall = load_use;
    assign bus.stall_count    = cnt_q;

endmodule

// File: tb/tb_dest_track_fwd.sv
// Scoreboard bench: directed scenarios then random traffic against a stage-history model.
// Two DUTs share stimulus; the second has a 2-bit counter to exercise saturation.
module tb_dest_track_fwd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dest_track_fwd_if #(.REG_W(5), .CNT_W(16)) bus  ();
    dest_track_fwd_if #(.REG_W(5), .CNT_W(2))  bus2 ();

    dest_track_fwd #(.REG_W(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    dest_track_fwd #(.REG_W(5), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        bit       rst;
        bit       stall;
        bit       flush;
        bit [4:0] ex_wr;
        bit       ex_rw;
        bit       ex_mr;
        bit [4:0] ex_rs;
        bit [4:0] ex_rt;
        bit [4:0] id_rs;
        bit [4:0] id_rt;
    } stim_t;

    typedef struct {
        int rg;
        bit wr;
        bit rd;
    } ent_t;

    typedef struct {
        int mem_reg; int mem_rw; int mem_mr;
        int wb_reg;  int wb_rw;
        int fa; int fb; int lu;
        int cnt; int cnt2;
    } exp_t;

    exp_t exp_q[$];
    ent_t stage[2];   // stage[0] = MEM, stage[1] = WB
    int   cnt_m, cnt2_m;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Newest matching writer wins; register 0 is never a forwarding source.
    function automatic int fwd_of(int src);
        for (int i = 0; i < 2; i++) begin
            if (stage[i].wr && stage[i].rg != 0 && stage[i].rg == src) return i + 1;
        end
        return 0;
    endfunction

    task automatic drive(stim_t s);
        rst               = s.rst;
        bus.stall         = s.stall;        bus2.stall        = s.stall;
        bus.flush         = s.flush;        bus2.flush        = s.flush;
        bus.ex_write_reg  = s.ex_wr;        bus2.ex_write_reg = s.ex_wr;
        bus.ex_reg_write  = s.ex_rw;        bus2.ex_reg_write = s.ex_rw;
        bus.ex_mem_read   = s.ex_mr;        bus2.ex_mem_read  = s.ex_mr;
        bus.ex_rs         = s.ex_rs;        bus2.ex_rs        = s.ex_rs;
        bus.ex_rt         = s.ex_rt;        bus2.ex_rt        = s.ex_rt;
        bus.id_rs         = s.id_rs;        bus2.id_rs        = s.id_rs;
        bus.id_rt         = s.id_rt;        bus2.id_rt        = s.id_rt;
    endtask

    // One pipeline cycle: drive mid-cycle, predict, then advance the model at the edge.
    task automatic step(stim_t s);
        exp_t e;
        bit   lu;
        @(negedge clk);
        drive(s);
        if (s.rst) begin
            stage[0] = '{0, 0, 0};
            stage[1] = '{0, 0, 0};
            cnt_m  = 0;
            cnt2_m = 0;
        end
        lu = s.ex_mr && s.ex_rw && !s.flush && s.ex_wr != 0 &&
             (s.ex_wr == s.id_rs || s.ex_wr == s.id_rt);
        e.mem_reg = stage[0].rg; e.mem_rw = int'(stage[0].wr); e.mem_mr = int'(stage[0].rd);
        e.wb_reg  = stage[1].rg; e.wb_rw  = int'(stage[1].wr);
        e.fa  = fwd_of(int'(s.ex_rs));
        e.fb  = fwd_of(int'(s.ex_rt));
        e.lu  = int'(lu);
        e.cnt = cnt_m;
        e.cnt2 = cnt2_m;
        exp_q.push_back(e);
        @(posedge clk);
        if (!s.rst && !s.stall) begin
            stage[1] = stage[0];
            stage[0] = '{int'(s.ex_wr), s.ex_rw && !s.flush, s.ex_mr && !s.flush};
            if (lu) begin
                if (cnt_m  < 65535) cnt_m++;
                if (cnt2_m < 3)     cnt2_m++;
            end
        end
    endtask

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mem_write_reg", int'(bus.mem_write_reg), e.mem_reg);
                chk("mem_reg_write", int'(bus.mem_reg_write), e.mem_rw);
                chk("mem_mem_read",  int'(bus.mem_mem_read),  e.mem_mr);
                chk("wb_write_reg",  int'(bus.wb_write_reg),  e.wb_reg);
                chk("wb_reg_write",  int'(bus.wb_reg_write),  e.wb_rw);
                chk("forward_a",     int'(bus.forward_a),     e.fa);
                chk("forward_b",     int'(bus.forward_b),     e.fb);
                chk("load_use_stall", int'(bus.load_use_stall), e.lu);
                chk("stall_count",   int'(bus.stall_count),   e.cnt);
                chk("stall_count_sat", int'(bus2.stall_count), e.cnt2);
                chk("forward_a_w2",  int'(bus2.forward_a),    e.fa);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        drive(idle());
        rst = 1'b1;

        // Reset state
        s = idle(); s.rst = 1; step(s); step(s);

        // MEM forward, then WB, then gone
        s = idle(); s.ex_wr = 9; s.ex_rw = 1; step(s);
        s = idle(); s.ex_rs = 9; s.ex_rt = 4; step(s); step(s); step(s);

        // MEM beats WB on equal destinations; register 0 never forwarded
        s = idle(); s.ex_wr = 7; s.ex_rw = 1; step(s); step(s);
        s = idle(); s.ex_rt = 7; s.ex_rs = 7; step(s);
        s = idle(); s.ex_wr = 0; s.ex_rw = 1; step(s);
        s = idle(); s.ex_rs = 0; s.ex_rt = 0; step(s);

        // Load-use with counting, then the same load squashed
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 5; s.id_rt = 5;
        step(s); step(s); step(s);
        s.flush = 1; step(s);
        s = idle(); s.ex_rs = 5; step(s);

        // Asynchronous reset with live MEM entry
        s = idle(); s.ex_wr = 5; s.ex_rw = 1; s.ex_mr = 1; step(s);
        s = idle(); s.rst = 1; step(s);

        // Stall hold with flush ignored
        s = idle(); s.ex_wr = 3; s.ex_rw = 1; step(s);
        s.ex_wr = 12; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1; s.ex_wr = 5'(20 + i); s.ex_rw = 1;
            s.flush = (i == 1); s.ex_rs = 12; s.ex_rt = 3;
            step(s);
        end
        s = idle(); s.ex_rs = 12; s.ex_rt = 3; step(s); step(s);

        // Saturation of the narrow counter
        s = idle(); s.rst = 1; step(s);
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 6; s.id_rs = 6;
        for (int i = 0; i < 6; i++) step(s);
        s = idle(); step(s);

        // Random traffic over a small register range to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.stall = ($urandom_range(0, 9) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.ex_wr = 5'($urandom_range(0, 7));
            s.ex_rw = 1'($urandom_range(0, 1));
            s.ex_mr = 1'($urandom_range(0, 1));
            s.ex_rs = 5'($urandom_range(0, 7));
            s.ex_rt = 5'($urandom_range(0, 7));
            s.id_rs = 5'($urandom_range(0, 7));
            s.id_rt = 5'($urandom_range(0, 7));
            step(s);
        end

        s = idle(); step(s);
        @(negedge clk); #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dest_track_fwd.md
Name: dest_track_fwd

Overview:
- Sits directly downstream of the 5-bit 3:1 destination-register select mux (rt / rd / $31) in the EX stage.
- Carries the selected write-register number and its control bits through the EX/MEM and MEM/WB pipeline registers.
- From the tracked destinations, generates the forwarding selects for the EX-stage ALU operand muxes and the load-use stall request for the ID stage.
- Also counts load-use stall cycles, for use as a performance counter.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  reset; one clock, asynchronous assertion, active-high.
- Stall  in  1  global freeze; all internal registers hold.
- Flush  in  1  squash the EX instruction on capture; a bubble enters MEM.
- ExWriteReg  in  REG_W  destination from the mux, EX stage.
- ExRegWrite  in  1  EX instruction writes the register file.
- ExMemRead  in  1  EX instruction is a load.
- ExRs  in  REG_W  rs of the EX instruction.
- ExRt  in  REG_W  rt of the EX instruction.
- IdRs  in  REG_W  rs of the ID instruction.
- IdRt  in  REG_W  rt of the ID instruction.
- MemWriteReg  out  REG_W  destination, MEM stage.
- MemRegWrite  out  1  register-write enable, MEM stage.
- WbWriteReg  out  REG_W  destination, WB stage.
- WbRegWrite  out  1  register-write enable, WB stage.
- ForwardA  out  2  operand A select: 0 = regfile, 1 = MEM result, 2 = WB result.
- ForwardB  out  2  operand B select, same encoding as ForwardA.
- LoadUseStall  out  1  request to stall IF/ID and insert a bubble into ID/EX.
- StallCount  out  CNT_W  saturating count of cycles with LoadUseStall high.

Behaviour:
- Reset (Rst high, asynchronous):
  - MemWriteReg, MemRegWrite, MemMemRead (internal), WbWriteReg, WbRegWrite, StallCount all go to 0.
  - Combinational outputs follow their inputs, so ForwardA/B = 0 and LoadUseStall = 0 while no EX load is pending.
  - Reset mid-operation discards all in-flight destinations immediately.
- Pipeline advance (posedge Clk, Stall = 0):
  - MEM stage <= {ExWriteReg, ExRegWrite & ~Flush, ExMemRead & ~Flush}.
  - WB stage <= {MemWriteReg, MemRegWrite}.
  - Latency: one cycle EX→MEM, two cycles EX→WB.
  - A flushed entry keeps its register number but has both enable bits cleared.
- Stall = 1:
  - All stage registers hold, and Flush is ignored.
  - A flush that coincides with Stall must be reasserted by the controller once Stall drops.
- Forwarding (combinational, same cycle). ForwardA priority:
  - 1 if MemRegWrite && MemWriteReg != 0 && MemWriteReg == ExRs;
  - else 2 if WbRegWrite && WbWriteReg != 0 && WbWriteReg == ExRs;
  - else 0.
- ForwardB uses the same rule with ExRt.
- When MEM and WB hold the same destination, MEM wins (newest value).
- Register 0 is never forwarded.
- Select value 3 is never produced.
- Load-use (combinational): LoadUseStall = ExMemRead && ExRegWrite && ExWriteReg != 0 && (ExWriteReg == IdRs || ExWriteReg == IdRt).
- LoadUseStall is forced to 0 while Flush = 1, because the load is being squashed.
- StallCount:
  - Increments at posedge Clk when LoadUseStall = 1 and Stall = 0.
  - Saturates at all-ones; no wrap-around.
  - Holds while Stall = 1.
- No writeback-to-ID forwarding is needed: the register file writes in the first half-cycle.

Decomposition:
- Shared package:
  - Forward-select encodings FWD_REGFILE = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2.
  - REG_ZERO = 5'd0.
  - Default REG_W.
- One natural sub-module: fwd_select, instantiated twice (operands A and B).
  - Inputs: source register number, MEM dest/enable, WB dest/enable.
  - Output: 2-bit select.

Test Plan:
- Reset: drive Rst high mid-stream with MemRegWrite = 1 → all stage outputs 0 and StallCount = 0 asynchronously, before the next edge.
- MEM forward: ExWriteReg = 9, ExRegWrite = 1 for one edge, then ExRs = 9, ExRt = 4 → ForwardA = 1, ForwardB = 0. After the next edge with a bubble in EX → ForwardA = 2. One edge later → ForwardA = 0.
- Priority and zero register:
  - MEM dest = 7 and WB dest = 7, both writing, ExRt = 7 → ForwardB = 1.
  - Dest = 0 with RegWrite = 1 and ExRs = 0 → ForwardA = 0.
- Load-use:
  - ExMemRead = 1, ExRegWrite = 1, ExWriteReg = 5, IdRt = 5 → LoadUseStall = 1, and StallCount increments by 1 per edge.
  - Same inputs with Flush = 1 → LoadUseStall = 0, and the MEM entry captured next has MemRegWrite = 0.
- Stall hold: with MEM dest = 12 and WB dest = 3, hold Stall = 1 for 3 edges while changing ExWriteReg → MEM and WB outputs unchanged. Flush asserted during Stall has no effect.
- Saturation: with CNT_W = 2, keep the load-use condition active for 5 edges → StallCount reads 1, 2, 3, 3, 3.
